// File: rtl/bcd_count_scan_pkg.sv
// Shared constants for the four-digit BCD counter with multiplexed display scan.
package bcd_count_scan_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam int         BCD_W      = 4;
    localparam logic [3:0] AN_RESET   = 4'b1110;

    // Active-low one-hot digit select for a 2-bit digit index.
    function automatic logic [3:0] an_decode(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_count_scan_digit.sv
// Single decade counter (0..9) with ripple carry/borrow; out-of-range values
// are treated as the wrap point so a corrupted digit recovers on the next step.
module bcd_digit
    import bcd_count_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             up,
    input  logic             clr,
    input  logic             cin,
    output logic [BCD_W-1:0] digit,
    output logic             cout
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;
    logic             at_limit;

    always_comb begin
        at_limit = up ? (digit_q >= 4'd9) : ((digit_q == 4'd0) || (digit_q > 4'd9));
        cout     = cin & at_limit;
        digit_d  = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (step && cin) begin
            if (at_limit) begin
                digit_d = up ? 4'd0 : 4'd9;
            end else begin
                digit_d = up ? (digit_q + 4'd1) : (digit_q - 4'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_count_scan.sv
// Four-digit BCD up/down counter stepped by a prescaler, with a free-running
// scan that multiplexes the digits onto one BCD output for a 7-segment driver.
module bcd_count_scan
    import bcd_count_scan_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        up,
    output logic [15:0] count,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        tick,
    output logic        carry
);

    localparam int            TW       = $clog2(TICK_DIV);
    localparam int            SW       = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
    logic [1:0]              digit_idx_q, digit_idx_d;
    logic [3:0]              an_q, an_d;
    logic [BCD_W-1:0]        bcd_out_q, bcd_out_d;
    logic                    tick_q, tick_d;
    logic                    carry_q, carry_d;
    logic                    step;
    logic [NUM_DIGITS:0]     chain;
    logic [NUM_DIGITS*BCD_W-1:0] count_w;

    // clr wins over a step landing on the same edge, which also kills tick/carry.
    assign step     = en & ~clr & (tick_cnt_q == TICK_MAX);
    assign chain[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .step  (step),
            .up    (up),
            .clr   (clr),
            .cin   (chain[i]),
            .digit (count_w[i*BCD_W +: BCD_W]),
            .cout  (chain[i+1])
        );
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clr) begin
            tick_cnt_d = '0;
        end else if (en) begin
            tick_cnt_d = (tick_cnt_q == TICK_MAX) ? '0 : (tick_cnt_q + 1'b1);
        end

        scan_cnt_d  = (scan_cnt_q == SCAN_MAX) ? '0 : (scan_cnt_q + 1'b1);
        digit_idx_d = (scan_cnt_q == SCAN_MAX) ? (digit_idx_q + 2'd1) : digit_idx_q;

        // Both display outputs come from the same index so they never disagree.
        an_d      = an_decode(digit_idx_q);
        bcd_out_d = count_w[{digit_idx_q, 2'b00} +: BCD_W];

        tick_d  = step;
        carry_d = step & chain[NUM_DIGITS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q  <= '0;
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            an_q        <= AN_RESET;
            bcd_out_q   <= '0;
            tick_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            bcd_out_q   <= bcd_out_d;
            tick_q      <= tick_d;
            carry_q     <= carry_d;
        end
    end

    assign count   = count_w;
    assign bcd_out = bcd_out_q;
    assign an      = an_q;
    assign tick    = tick_q;
    assign carry   = carry_q;

endmodule

// File: tb/tb_bcd_count_scan.sv
// Directed table-driven bench for bcd_count_scan with TICK_DIV=4, SCAN_DIV=2,
// plus hand sequences for the long count, display scan and async reset cases.
module tb_bcd_count_scan;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        up;
    logic [15:0] count;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        tick;
    logic        carry;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        en;
        logic        clr;
        logic        up;
        int          ncyc;
        logic [15:0] exp_count;
        logic        exp_tick;
        logic        exp_carry;
    } vec_t;

    vec_t vecs[23];

    bcd_count_scan #(
        .TICK_DIV (4),
        .SCAN_DIV (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .up      (up),
        .count   (count),
        .bcd_out (bcd_out),
        .an      (an),
        .tick    (tick),
        .carry   (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        up    = 1'b1;
        run_cycles(2);
        rst_n = 1'b1;
    endtask

    initial begin : main
        logic [3:0] an_pat[4];
        logic [3:0] dig_pat[4];
        logic [3:0] prev_an;
        bit         found;
        int         k;

        an_pat  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        dig_pat = '{4'h4, 4'h3, 4'h2, 4'h1};

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 3, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1, 16'h0001, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1, 16'h0001, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 5, 16'h0001, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 2, 16'h0001, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 3, 16'h0001, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1, 16'h0002, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4, 16'h0001, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4, 16'h9999, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4, 16'h9998, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 4, 16'h9999, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4, 16'h0000, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 4, 16'h0001, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 3, 16'h0001, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1, 16'h0000, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 3, 16'h0000, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 1, 16'h0001, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 2, 16'h0001, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 2, 16'h0000, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 8, 16'h0002, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 1, 16'h0000, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 4, 16'h0001, 1'b1, 1'b0};

        // Reset values, then 40 enabled cycles with a tick every fourth cycle.
        do_reset();
        check_output("rst_count", count, 16'h0000);
        check_output("rst_an", {12'h0, an}, 16'h000E);
        check_output("rst_bcd", {12'h0, bcd_out}, 16'h0000);
        check_output("rst_tick", {15'h0, tick}, 16'h0000);
        check_output("rst_carry", {15'h0, carry}, 16'h0000);

        en = 1'b1;
        up = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            run_cycles(1);
            check_output($sformatf("run40_tick_c%0d", i), {15'h0, tick}, {15'h0, (i % 4) == 0});
            check_output($sformatf("run40_carry_c%0d", i), {15'h0, carry}, 16'h0000);
        end
        check_output("run40_count", count, 16'h0010);
        up = 1'b0;
        run_cycles(4);
        check_output("borrow_0010_to_0009", count, 16'h0009);

        // Table of directed vectors from a fresh reset.
        do_reset();
        for (int v = 0; v < 23; v++) begin
            en  = vecs[v].en;
            clr = vecs[v].clr;
            up  = vecs[v].up;
            run_cycles(vecs[v].ncyc);
            check_output($sformatf("vec%0d_count", v), count, vecs[v].exp_count);
            check_output($sformatf("vec%0d_tick", v), {15'h0, tick}, {15'h0, vecs[v].exp_tick});
            check_output($sformatf("vec%0d_carry", v), {15'h0, carry}, {15'h0, vecs[v].exp_carry});
        end
        clr = 1'b0;

        // Count to 1234 then watch the scan sequence.
        do_reset();
        en = 1'b1;
        up = 1'b1;
        run_cycles(1234 * 4);
        check_output("count_1234", count, 16'h1234);
        en = 1'b0;
        prev_an = an;
        found   = 1'b0;
        for (int w = 0; w < 8 && !found; w++) begin
            run_cycles(1);
            if (an !== prev_an) found = 1'b1;
        end
        check_output("scan_an_moves", {15'h0, found}, 16'h0001);
        k = 0;
        for (int j = 0; j < 4; j++) begin
            if (an === an_pat[j]) k = j;
        end
        for (int i = 0; i < 16; i++) begin
            check_output($sformatf("scan_an_c%0d", i), {12'h0, an}, {12'h0, an_pat[(k + i / 2) % 4]});
            check_output($sformatf("scan_bcd_c%0d", i), {12'h0, bcd_out}, {12'h0, dig_pat[(k + i / 2) % 4]});
            run_cycles(1);
        end

        // Asynchronous reset mid-scan with a nonzero count.
        do_reset();
        en = 1'b1;
        up = 1'b1;
        run_cycles(57 * 4);
        check_output("count_0057", count, 16'h0057);
        en = 1'b0;
        run_cycles(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_count", count, 16'h0000);
        check_output("async_an", {12'h0, an}, 16'h000E);
        check_output("async_bcd", {12'h0, bcd_out}, 16'h0000);
        check_output("async_tick", {15'h0, tick}, 16'h0000);
        check_output("async_carry", {15'h0, carry}, 16'h0000);
        run_cycles(2);
        rst_n = 1'b1;
        run_cycles(12);
        check_output("hold_after_rst_count", count, 16'h0000);
        check_output("hold_after_rst_tick", {15'h0, tick}, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bcd_count_scan.md
BCD_COUNT_SCAN -- requirements
Module: bcd_count_scan

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clk cycles per count step (min 2).
REQ-002 Parameter SCAN_DIV, default 50_000, clk cycles per display digit slot (min 2).
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable; 0 freezes the count prescaler and the count.
REQ-006 clr  input  1  synchronous clear of the count and the count prescaler.
REQ-007 up  input  1  direction: 1 increments, 0 decrements.
REQ-008 count  output  16  four packed BCD digits, [3:0] ones ... [15:12] thousands.
REQ-009 bcd_out  output  4  currently scanned digit; feeds the downstream 7-segment decoder.
REQ-010 an  output  4  digit select, active-low one-hot, an[0] = ones.
REQ-011 tick  output  1  one-cycle pulse, high in the cycle after each count step.
REQ-012 carry  output  1  one-cycle pulse, high with tick when the count wraps.

Function
REQ-013 The count prescaler counts 0..TICK_DIV-1 while en=1, holds while en=0, and wraps to 0 after TICK_DIV-1.
REQ-014 On the edge where the prescaler wraps, count steps by one and tick is registered high for exactly one cycle.
REQ-015 Decade arithmetic is per digit: up=1 carries 9->0 into the next digit; up=0 borrows 0->9 from the next digit.
REQ-016 Wrap-around: 9999+1 -> 0000 and 0000-1 -> 9999, each with carry=1 alongside tick.
REQ-017 count digits never hold values 10-15; if one is forced there, the next step treats it as 9 (up) or 0 (down) wrap.
REQ-018 clr=1 clears count and the prescaler on the next edge, takes priority over a simultaneous step, and suppresses tick and carry that cycle.
REQ-019 up is sampled only on the step edge; changing up mid-period takes effect at the next step.
REQ-020 The scan prescaler is free-running (independent of en and clr), counts 0..SCAN_DIV-1, and advances the digit index 0->1->2->3->0 on wrap.
REQ-021 an and bcd_out are both registered and update on the same edge, so bcd_out always equals the digit selected by an.
REQ-022 If count changes while a digit is displayed, bcd_out shows the new value from the cycle after the change.

Reset
REQ-023 rst_n=0 immediately sets count=16'h0000, bcd_out=4'h0, an=4'b1110, tick=0, carry=0, both prescalers=0, and digit index=0.
REQ-024 After rst_n deasserts, the first count step occurs TICK_DIV enabled cycles later.
REQ-025 Reset mid-period discards the partial prescaler progress with no tick or carry.

Structure
REQ-026 A shared package/include holds the digit-count constant (4), the BCD width (4), and the an reset pattern (4'b1110).
REQ-027 One sub-module, bcd_digit, is instantiated four times: a 4-bit decade counter with step, up, clear, carry-in and carry-out.
REQ-028 The prescalers and the scan mux are in the top level, with prescaler widths derived from the parameters by $clog2.

Verification
REQ-029 All benches use TICK_DIV=4 and SCAN_DIV=2.
REQ-030 Reset then en=1, up=1, 40 cycles -> count=0x0010 at cycle 40, tick every 4th cycle, carry never asserted.
REQ-031 Preload near 9999 by stepping, then up=1 through the wrap -> 9999 -> 0000 with tick=1 and carry=1 in the same cycle.
REQ-032 From 0000, up=0, one step -> count=0x9999 with carry=1; the next step -> 0x9998 with carry=0.
REQ-033 clr=1 on the prescaler-wrap edge -> count=0x0000 and tick=0 that cycle; the next tick comes 4 cycles after clr drops.
REQ-034 count=0x1234, observe 16 cycles -> (an, bcd_out) cycles through (1110,4), (1101,3), (1011,2), (0111,1), 2 cycles each.
REQ-035 Assert rst_n=0 asynchronously mid-scan with count=0x0057 -> outputs reach reset values before the next clk edge; en=0 thereafter holds count at 0.
